reaction_ctrl: RTL and testbench



---
 rtl/reaction_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_reaction_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_ctrl.sv
// Reaction-time game sequencer: arms on start and waits a pseudo-random delay.
// It then times the player's reaction in 3-digit BCD ms and reports the score.
module reaction_ctrl #(
    parameter int CLK_PER_MS   = 50000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int TIMEOUT_MS   = 999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_btn,
    input  logic        react_btn,
    output logic        led_go,
    output logic        led_foul,
    output logic        busy,
    output logic        timeout,
    output logic [3:0]  dig0,
    output logic [3:0]  dig1,
    output logic [3:0]  dig2,
    output logic [11:0] score,
    output logic        score_valid
);

    localparam int PW = (CLK_PER_MS > 2) ? $clog2(CLK_PER_MS) : 1;
    localparam int DW = $clog2(MIN_DELAY_MS + 1024);
    localparam logic [11:0] TO_M1_BCD = {4'((TIMEOUT_MS - 1) / 100),
                                         4'(((TIMEOUT_MS - 1) / 10) % 10),
                                         4'((TIMEOUT_MS - 1) % 10)};
    localparam logic [11:0] NO_SCORE  = 12'hFFF;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_GO, S_DONE, S_FOUL} state_t;

    state_t          state_q, state_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [DW-1:0]   delay_q, delay_d;
    logic [11:0]     digs_q, digs_d;
    logic [11:0]     score_q, score_d;
    logic            timeout_q, timeout_d;
    logic            score_valid_q, score_valid_d;

    logic            start_meta_q, start_sync_q, start_dly_q;
    logic            react_meta_q, react_sync_q, react_dly_q;
    logic            start_edge, react_edge, ms_tick, arm;

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v[3:0] != 4'd9) begin
            r[3:0] = v[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (v[7:4] != 4'd9) begin
                r[7:4] = v[7:4] + 4'd1;
            end else begin
                r[7:4]  = 4'd0;
                r[11:8] = (v[11:8] == 4'd9) ? 4'd0 : v[11:8] + 4'd1;
            end
        end
        return r;
    endfunction

    function automatic logic [11:0] bcd_to_bin(input logic [11:0] v);
        return 12'(v[11:8]) * 12'd100 + 12'(v[7:4]) * 12'd10 + 12'(v[3:0]);
    endfunction

    // Both buttons are asynchronous: two-flop synchronizer plus a rising-edge delay flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_meta_q <= 1'b0;
            start_sync_q <= 1'b0;
            start_dly_q  <= 1'b0;
            react_meta_q <= 1'b0;
            react_sync_q <= 1'b0;
            react_dly_q  <= 1'b0;
        end else begin
            start_meta_q <= start_btn;
            start_sync_q <= start_meta_q;
            start_dly_q  <= start_sync_q;
            react_meta_q <= react_btn;
            react_sync_q <= react_meta_q;
            react_dly_q  <= react_sync_q;
        end
    end

    assign start_edge = start_sync_q & ~start_dly_q;
    assign react_edge = react_sync_q & ~react_dly_q;
    assign ms_tick    = (presc_q == PW'(CLK_PER_MS - 1));
    assign arm        = start_edge && (state_q inside {S_IDLE, S_DONE, S_FOUL});

    always_comb begin
        state_d       = state_q;
        delay_d       = delay_q;
        digs_d        = digs_q;
        score_d       = score_q;
        timeout_d     = timeout_q;
        score_valid_d = 1'b0;
        lfsr_d        = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        case (state_q)
            S_IDLE, S_DONE, S_FOUL: begin
                if (arm) begin
                    state_d   = S_WAIT;
                    delay_d   = DW'(MIN_DELAY_MS) + DW'(lfsr_q[9:0]);
                    score_d   = NO_SCORE;
                    timeout_d = 1'b0;
                end
            end
            S_WAIT: begin
                // A react during the wait is a false start even on the final tick
                if (react_edge) begin
                    state_d = S_FOUL;
                    digs_d  = 12'h000;
                    score_d = NO_SCORE;
                end else if (ms_tick) begin
                    if (delay_q <= DW'(1)) begin
                        state_d = S_GO;
                        digs_d  = 12'h000;
                    end else begin
                        delay_d = delay_q - DW'(1);
                    end
                end
            end
            S_GO: begin
                if (react_edge) begin
                    state_d       = S_DONE;
                    score_d       = bcd_to_bin(digs_q);
                    score_valid_d = 1'b1;
                end else if (ms_tick) begin
                    digs_d = bcd_inc(digs_q);
                    if (digs_q == TO_M1_BCD) begin
                        state_d       = S_DONE;
                        timeout_d     = 1'b1;
                        score_d       = bcd_to_bin(bcd_inc(digs_q));
                        score_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Restarting the prescaler on each transition gives every state a full first ms
        if (state_d != state_q || ms_tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            lfsr_q        <= 16'hACE1;
            presc_q       <= '0;
            delay_q       <= '0;
            digs_q        <= 12'h000;
            score_q       <= NO_SCORE;
            timeout_q     <= 1'b0;
            score_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            presc_q       <= presc_d;
            delay_q       <= delay_d;
            digs_q        <= digs_d;
            score_q       <= score_d;
            timeout_q     <= timeout_d;
            score_valid_q <= score_valid_d;
        end
    end

    assign led_go      = (state_q == S_GO);
    assign led_foul    = (state_q == S_FOUL);
    assign busy        = (state_q == S_WAIT) || (state_q == S_GO);
    assign timeout     = timeout_q;
    assign dig0        = digs_q[3:0];
    assign dig1        = digs_q[7:4];
    assign dig2        = digs_q[11:8];
    assign score       = score_q;
    assign score_valid = score_valid_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl with a 4-clock millisecond and a 20 ms timeout.
// The pre-GO delay is predicted from an independent LFSR model clocked alongside the design.
module tb_reaction_ctrl;

    localparam int CPM   = 4;
    localparam int MIN   = 2;
    localparam int TO    = 20;
    localparam int LIMIT = CPM * (MIN + 1024) + 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_btn = 1'b0;
    logic        react_btn = 1'b0;
    logic        led_go, led_foul, busy, timeout, score_valid;
    logic [3:0]  dig0, dig1, dig2;
    logic [11:0] score;

    int errors = 0;
    int checks = 0;
    int sv_total = 0;
    int armed_delay = 0;
    logic [15:0] m_lfsr, m_prev;

    reaction_ctrl #(.CLK_PER_MS(CPM), .MIN_DELAY_MS(MIN), .TIMEOUT_MS(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .react_btn(react_btn),
        .led_go(led_go), .led_foul(led_foul), .busy(busy), .timeout(timeout),
        .dig0(dig0), .dig1(dig1), .dig2(dig2), .score(score), .score_valid(score_valid)
    );

    always #5 clk = ~clk;

    // Reference LFSR: taps 16,14,13,11, seeded 16'hACE1 by reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    always @(negedge clk) begin
        if (score_valid === 1'b1) sv_total++;
    end

    // Leaves the bench 1 ns after the edge at which the design reacts to the start press
    task press_start;
        @(posedge clk);
        #1 start_btn = 1'b1;
        repeat (3) @(posedge clk);
        #1 start_btn = 1'b0;
        armed_delay = CPM * (MIN + int'(m_prev[9:0]));
    endtask

    task press_react;
        @(posedge clk);
        #1 react_btn = 1'b1;
        repeat (3) @(posedge clk);
        #1 react_btn = 1'b0;
    endtask

    task wait_go(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (!ok && cyc < LIMIT) begin
            @(posedge clk);
            #1 cyc++;
            if (led_go === 1'b1) ok = 1'b1;
        end
    endtask

    task test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({led_go, led_foul, busy, timeout, score_valid} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags got=%b want=00000", {led_go, led_foul, busy, timeout, score_valid});
        end
        checks++;
        if ({dig2, dig1, dig0} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_digits got=%h want=000", {dig2, dig1, dig0});
        end
        checks++;
        if (score !== 12'hFFF) begin
            errors++;
            $display("[TB] FAIL reset_score got=%h want=fff", score);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task test_start_delay;
        int cyc;
        bit ok;
        @(posedge clk);
        #1 start_btn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL busy_before_3clk got=%b want=0", busy);
        end
        @(posedge clk);
        #1 start_btn = 1'b0;
        armed_delay = CPM * (MIN + int'(m_prev[9:0]));
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_at_3clk got=%b want=1", busy);
        end
        wait_go(cyc, ok);
        checks++;
        if (!ok || cyc < armed_delay - 1 || cyc > armed_delay + 1) begin
            errors++;
            $display("[TB] FAIL go_delay got=%0d cycles (seen=%0d) want=%0d", cyc, ok, armed_delay);
        end
    endtask

    task test_react_13;
        int sv0;
        sv0 = sv_total;
        repeat (50) @(posedge clk);
        #1 react_btn = 1'b1;
        repeat (3) @(posedge clk);
        #1 react_btn = 1'b0;
        checks++;
        if ({led_go, busy, score_valid} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL react13_flags got go,busy,sv=%b want=001", {led_go, busy, score_valid});
        end
        checks++;
        if ({dig2, dig1, dig0} !== 12'h013 || score !== 12'd13) begin
            errors++;
            $display("[TB] FAIL react13_result got digits=%h score=%0d want 013/13", {dig2, dig1, dig0}, score);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (sv_total - sv0 != 1 || {dig2, dig1, dig0} !== 12'h013) begin
            errors++;
            $display("[TB] FAIL react13_pulse_frozen got pulses=%0d digits=%h want 1/013", sv_total - sv0, {dig2, dig1, dig0});
        end
    endtask

    task test_false_start;
        int sv0;
        press_start;
        checks++;
        if ({busy, timeout} !== 2'b10 || score !== 12'hFFF) begin
            errors++;
            $display("[TB] FAIL rearm got busy,timeout=%b score=%h want 10/fff", {busy, timeout}, score);
        end
        sv0 = sv_total;
        press_react;
        checks++;
        if ({led_foul, led_go, busy} !== 3'b100 || score !== 12'hFFF || {dig2, dig1, dig0} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL foul_state got foul,go,busy=%b score=%h digits=%h want 100/fff/000",
                     {led_foul, led_go, busy}, score, {dig2, dig1, dig0});
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sv_total != sv0) begin
            errors++;
            $display("[TB] FAIL foul_no_valid got pulses=%0d want=0", sv_total - sv0);
        end
        press_start;
        checks++;
        if ({led_foul, busy} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL foul_restart got foul,busy=%b want=01", {led_foul, busy});
        end
    endtask

    task test_timeout;
        int cyc, n, sv0;
        bit ok;
        wait_go(cyc, ok);
        checks++;
        if (!ok || cyc < armed_delay - 1 || cyc > armed_delay + 1) begin
            errors++;
            $display("[TB] FAIL go_delay2 got=%0d cycles (seen=%0d) want=%0d", cyc, ok, armed_delay);
        end
        sv0 = sv_total;
        n = 0;
        while (led_go === 1'b1 && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        checks++;
        if (n != CPM * TO) begin
            errors++;
            $display("[TB] FAIL timeout_len got=%0d cycles want=%0d", n, CPM * TO);
        end
        checks++;
        if ({dig2, dig1, dig0} !== 12'h020 || score !== 12'd20 || {timeout, score_valid} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL timeout_result got digits=%h score=%0d to,sv=%b want 020/20/11",
                     {dig2, dig1, dig0}, score, {timeout, score_valid});
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sv_total - sv0 != 1 || timeout !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_hold got pulses=%0d timeout=%b want 1/1", sv_total - sv0, timeout);
        end
        press_start;
        checks++;
        if (timeout !== 1'b0 || score !== 12'hFFF || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_clear got timeout=%b score=%h busy=%b want 0/fff/1", timeout, score, busy);
        end
    endtask

    task test_foul_on_last_tick;
        repeat (armed_delay - 3) @(posedge clk);
        #1 react_btn = 1'b1;
        repeat (3) @(posedge clk);
        #1 react_btn = 1'b0;
        checks++;
        if ({led_foul, led_go} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL last_tick_foul got foul,go=%b want=10", {led_foul, led_go});
        end
    endtask

    task test_tick_coincide;
        int cyc;
        bit ok;
        press_start;
        wait_go(cyc, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL coincide_go got no GO within %0d cycles want GO", LIMIT);
        end
        repeat (29) @(posedge clk);
        #1 react_btn = 1'b1;
        repeat (3) @(posedge clk);
        #1 react_btn = 1'b0;
        checks++;
        if ({dig2, dig1, dig0} !== 12'h007 || score !== 12'd7 || led_go !== 1'b0) begin
            errors++;
            $display("[TB] FAIL coincide_score got digits=%h score=%0d go=%b want 007/7/0",
                     {dig2, dig1, dig0}, score, led_go);
        end
    endtask

    task test_reset_mid_go;
        int cyc, sv0;
        bit ok;
        press_start;
        wait_go(cyc, ok);
        repeat (21) @(posedge clk);
        #1;
        checks++;
        if (!ok || {dig2, dig1, dig0} !== 12'h005) begin
            errors++;
            $display("[TB] FAIL pre_reset_count got digits=%h go_seen=%0d want 005/1", {dig2, dig1, dig0}, ok);
        end
        sv0 = sv_total;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({led_go, led_foul, busy, timeout, score_valid} !== 5'b0 || {dig2, dig1, dig0} !== 12'h000 || score !== 12'hFFF) begin
            errors++;
            $display("[TB] FAIL async_reset got flags=%b digits=%h score=%h want 00000/000/fff",
                     {led_go, led_foul, busy, timeout, score_valid}, {dig2, dig1, dig0}, score);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        checks++;
        if (sv_total != sv0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_no_valid got pulses=%0d busy=%b want 0/0", sv_total - sv0, busy);
        end
    endtask

    task test_back_to_back;
        int cyc;
        bit ok;
        press_start;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fresh_round_busy got=%b want=1", busy);
        end
        wait_go(cyc, ok);
        checks++;
        if (!ok || cyc < armed_delay - 1 || cyc > armed_delay + 1) begin
            errors++;
            $display("[TB] FAIL fresh_round_delay got=%0d cycles (seen=%0d) want=%0d", cyc, ok, armed_delay);
        end
        press_react;
        checks++;
        if (led_go !== 1'b0 || score !== 12'd0 || {dig2, dig1, dig0} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL first_ms_react got go=%b score=%0d digits=%h want 0/0/000", led_go, score, {dig2, dig1, dig0});
        end
    endtask

    initial begin
        test_reset;
        test_start_delay;
        test_react_13;
        test_false_start;
        test_timeout;
        test_foul_on_last_tick;
        test_tick_coincide;
        test_reset_mid_go;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
